// File: rtl/sc_frame_loader_if.sv
// Host byte stream, transmitter field/control bus and status of the slow-control frame loader.
// The loader connects through the slave modport; the host/transmitter side uses the master modport.
interface sc_frame_loader_if #(
  parameter int FRAME_BITS = 829
);
  logic [7:0]            byte_in;
  logic                  byte_valid_in;
  logic                  byte_ready_out;
  logic [FRAME_BITS-1:0] frame_out;
  logic                  start_out;
  logic [1:0]            tx_state_in;
  logic                  busy_out;
  logic                  done_out;
  logic [1:0]            err_code_out;
  logic [15:0]           frame_cnt_out;

  modport master (
    output byte_in, byte_valid_in, tx_state_in,
    input  byte_ready_out, frame_out, start_out, busy_out, done_out,
           err_code_out, frame_cnt_out
  );

  modport slave (
    input  byte_in, byte_valid_in, tx_state_in,
    output byte_ready_out, frame_out, start_out, busy_out, done_out,
           err_code_out, frame_cnt_out
  );
endinterface

// File: rtl/sc_frame_loader.sv
// Assembles the MAROC slow-control frame from a byte stream, publishes it to the
// serial transmitter, issues a one-cycle start and supervises the transfer.
module sc_frame_loader #(
  parameter int FRAME_BITS = 829,
  parameter int BYTE_COUNT = 104,
  parameter int GAP_CYCLES = 4096,
  parameter int TX_TIMEOUT = 2047
) (
  input  logic          clk_in,
  input  logic          reset_in,
  sc_frame_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_LOAD, S_START, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_GAP  = 2'd1,
    ERR_TX   = 2'd2
  } err_t;

  localparam logic [6:0]  LAST_BYTE = 7'(BYTE_COUNT - 1);
  localparam logic [12:0] GAP_LAST  = 13'(GAP_CYCLES - 1);
  localparam logic [10:0] TX_LAST   = 11'(TX_TIMEOUT);
  localparam logic [1:0]  TX_SENDING = 2'd2;
  localparam logic [1:0]  TX_FINAL   = 2'd3;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic [FRAME_BITS-1:0] frame_q;
  logic [6:0]            byte_cnt_q;
  logic [12:0]           gap_ctr_q;
  logic [10:0]           tx_ctr_q;
  logic                  seen_send_q;
  err_t                  err_q;
  logic [15:0]           frame_cnt_q;

  logic ready;
  logic accept;
  logic last_byte;
  logic gap_expired;
  logic tx_final;
  logic tx_expired;

  assign accept      = bus.byte_valid_in && ready;
  assign last_byte   = (byte_cnt_q == LAST_BYTE);
  assign gap_expired = (state_q == S_RECV) && !accept && (gap_ctr_q == GAP_LAST);
  // seen_send gates FINAL so a FINAL left over from the previous transfer is ignored.
  assign tx_final    = seen_send_q && (bus.tx_state_in == TX_FINAL);
  assign tx_expired  = (tx_ctr_q == TX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RECV;
      S_RECV: begin
        if (accept && last_byte) state_d = S_LOAD;
        else if (gap_expired)    state_d = S_IDLE;
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_final)        state_d = S_DONE;
        else if (tx_expired) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready        = 1'b0;
    bus.start_out = 1'b0;
    bus.busy_out  = 1'b1;
    bus.done_out  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready        = 1'b1;
        bus.busy_out = 1'b0;
      end
      S_RECV:  ready         = 1'b1;
      S_START: bus.start_out = 1'b1;
      S_DONE:  bus.done_out  = 1'b1;
      default: ;
    endcase
  end

  // Byte k lands in bits [8k+7:8k]; bits of the last byte beyond the frame have no home.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (byte_cnt_q == 7'(i / 8)) shadow_d[i] = bus.byte_in[3'(i % 8)];
    end
  end

  // NOTE: the shadow and published frame are wide registers but still take the async reset to zero.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      shadow_q    <= '0;
      frame_q     <= '0;
      byte_cnt_q  <= '0;
      gap_ctr_q   <= '0;
      tx_ctr_q    <= '0;
      seen_send_q <= 1'b0;
      err_q       <= ERR_NONE;
      frame_cnt_q <= '0;
    end else begin
      if (accept) shadow_q <= shadow_d;

      if (accept)           byte_cnt_q <= last_byte ? 7'd0 : byte_cnt_q + 7'd1;
      else if (gap_expired) byte_cnt_q <= 7'd0;

      if (accept || state_q != S_RECV) gap_ctr_q <= '0;
      else                             gap_ctr_q <= gap_ctr_q + 13'd1;

      if (state_q == S_LOAD) frame_q <= shadow_q;

      if (state_q == S_START) begin
        tx_ctr_q    <= '0;
        seen_send_q <= 1'b0;
      end else if (state_q == S_WAIT) begin
        tx_ctr_q <= tx_ctr_q + 11'd1;
        if (bus.tx_state_in == TX_SENDING) seen_send_q <= 1'b1;
      end

      if (state_q == S_IDLE && accept)                     err_q <= ERR_NONE;
      else if (gap_expired)                                err_q <= ERR_GAP;
      else if (state_q == S_WAIT && !tx_final && tx_expired) err_q <= ERR_TX;

      if (state_q == S_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.byte_ready_out = ready;
  assign bus.frame_out      = frame_q;
  assign bus.err_code_out   = err_q;
  assign bus.frame_cnt_out  = frame_cnt_q;

endmodule

// File: tb/tb_sc_frame_loader.sv
// Directed bench for sc_frame_loader with a behavioural transmitter state model.
module tb_sc_frame_loader;
  localparam int FRAME_BITS = 829;
  localparam int BYTE_COUNT = 104;
  localparam int GAP_CYCLES = 4096;
  localparam int TX_TIMEOUT = 2047;

  logic clk_in = 1'b0;
  logic reset_in;
  always #100 clk_in = ~clk_in;

  sc_frame_loader_if #(.FRAME_BITS(FRAME_BITS)) bus ();

  sc_frame_loader #(
    .FRAME_BITS(FRAME_BITS),
    .BYTE_COUNT(BYTE_COUNT),
    .GAP_CYCLES(GAP_CYCLES),
    .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] bytes_sent [BYTE_COUNT];

  logic       model_on;
  logic [1:0] forced_state;
  logic [1:0] model_state = 2'd0;
  int         model_cnt = 0;

  assign bus.tx_state_in = model_on ? model_state : forced_state;

  // Transmitter: PREPARE for 1 cycle after start, SENDING for 829 cycles, then FINAL until next start.
  always @(negedge clk_in) begin
    if (model_on) begin
      if (bus.start_out) begin
        model_state = 2'd1;
        model_cnt   = 0;
      end else if (model_state == 2'd1) begin
        model_state = 2'd2;
        model_cnt   = 1;
      end else if (model_state == 2'd2) begin
        if (model_cnt == 829) model_state = 2'd3;
        else                  model_cnt++;
      end
    end
  end

  function automatic logic [7:0] pat(input int kind, input int k);
    case (kind)
      0:       return 8'(k);
      1:       return 8'(255 - k);
      2:       return 8'(k * 3 + 1);
      3:       return 8'(k) ^ 8'h5A;
      4:       return 8'(k * 7 + 13);
      default: return 8'(k) ^ 8'hC3;
    endcase
  endfunction

  function automatic int first_bad_bit();
    for (int i = 0; i < FRAME_BITS; i++)
      if (bus.frame_out[i] !== bytes_sent[i / 8][i % 8]) return i;
    return -1;
  endfunction

  task automatic cycle();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    while (!bus.byte_ready_out && n < 3000) begin
      cycle();
      n++;
    end
    if (!bus.byte_ready_out) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout ready=%b after %0d cycles, want 1", bus.byte_ready_out, n);
    end
    cycle();
  endtask

  task automatic send_frame(input int kind, input int first);
    for (int k = first; k < BYTE_COUNT; k++) begin
      bytes_sent[k] = pat(kind, k);
      send_byte(bytes_sent[k]);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done_out && cyc < 3000) begin
      cycle();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_in = 1'b1;
    bus.byte_in = 8'h00;
    bus.byte_valid_in = 1'b0;
    model_on = 1'b1;
    forced_state = 2'd0;
    repeat (3) @(negedge clk_in);
    checks++; if (bus.byte_ready_out !== 1'b1) begin failures++; $display("FAIL rst_ready got %b want 1", bus.byte_ready_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", bus.busy_out); end
    checks++; if (bus.start_out !== 1'b0) begin failures++; $display("FAIL rst_start got %b want 0", bus.start_out); end
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", bus.done_out); end
    checks++; if (bus.err_code_out !== 2'd0) begin failures++; $display("FAIL rst_err got %0d want 0", bus.err_code_out); end
    checks++; if (bus.frame_cnt_out !== 16'd0) begin failures++; $display("FAIL rst_cnt got %0d want 0", bus.frame_cnt_out); end
    checks++; if (bus.frame_out !== '0) begin failures++; $display("FAIL rst_frame got nonzero want 0"); end
    reset_in = 1'b0;
    cycle();
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got %b want 0", bus.busy_out); end
  endtask

  task automatic test_nominal();
    int bad;
    int starts = 0;
    int dones = 0;
    send_frame(0, 0);
    bus.byte_valid_in = 1'b0;
    checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL nom_load_ready got %b want 0", bus.byte_ready_out); end
    checks++; if (bus.start_out !== 1'b0) begin failures++; $display("FAIL nom_load_start got %b want 0", bus.start_out); end
    cycle();
    checks++; if (bus.start_out !== 1'b1) begin failures++; $display("FAIL nom_start_e1 got %b want 1", bus.start_out); end
    checks++; if (bus.frame_out[7:0] !== 8'h00) begin failures++; $display("FAIL nom_byte0 got %h want 00", bus.frame_out[7:0]); end
    checks++; if (bus.frame_out[15:8] !== 8'h01) begin failures++; $display("FAIL nom_byte1 got %h want 01", bus.frame_out[15:8]); end
    checks++; if (bus.frame_out[828:824] !== 5'h07) begin failures++; $display("FAIL nom_top_bits got %h want 07", bus.frame_out[828:824]); end
    bad = first_bad_bit();
    checks++; if (bad != -1) begin failures++; $display("FAIL nom_frame bad bit %0d got %b want %b", bad, bus.frame_out[bad], ~bus.frame_out[bad]); end
    cycle();
    checks++; if (bus.start_out !== 1'b0) begin failures++; $display("FAIL nom_start_e2 got %b want 0", bus.start_out); end
    for (int n = 0; n < 1000; n++) begin
      if (bus.start_out) starts++;
      if (bus.done_out)  dones++;
      cycle();
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL nom_extra_starts got %0d want 0", starts); end
    checks++; if (dones != 1) begin failures++; $display("FAIL nom_done_pulses got %0d want 1", dones); end
    checks++; if (bus.frame_cnt_out !== 16'd1) begin failures++; $display("FAIL nom_cnt got %0d want 1", bus.frame_cnt_out); end
    checks++; if (bus.err_code_out !== 2'd0) begin failures++; $display("FAIL nom_err got %0d want 0", bus.err_code_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL nom_busy_after got %b want 0", bus.busy_out); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    int cyc;
    for (int k = 0; k < 40; k++) send_byte(pat(1, k));
    bus.byte_valid_in = 1'b0;
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL mid_recv_busy got %b want 1", bus.busy_out); end
    reset_in = 1'b1;
    #1;
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b want 0", bus.busy_out); end
    checks++; if (bus.byte_ready_out !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %b want 1", bus.byte_ready_out); end
    checks++; if (bus.frame_out !== '0) begin failures++; $display("FAIL mid_rst_frame got nonzero want 0"); end
    checks++; if (bus.frame_cnt_out !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt got %0d want 0", bus.frame_cnt_out); end
    @(negedge clk_in);
    reset_in = 1'b0;
    cycle();
    send_frame(1, 0);
    bus.byte_valid_in = 1'b0;
    cycle();
    bad = first_bad_bit();
    checks++; if (bad != -1) begin failures++; $display("FAIL mid_new_frame bad bit %0d got %b want %b", bad, bus.frame_out[bad], ~bus.frame_out[bad]); end
    wait_done(cyc);
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL mid_done_timeout got %b want 1 after %0d cycles", bus.done_out, cyc); end
    cycle();
    checks++; if (bus.frame_cnt_out !== 16'd1) begin failures++; $display("FAIL mid_cnt got %0d want 1", bus.frame_cnt_out); end
  endtask

  task automatic test_back_to_back();
    int bad;
    int cyc;
    int ready_seen = 0;
    int n = 0;
    send_frame(2, 0);
    bus.byte_in = 8'hAA;
    checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL bp_load_ready got %b want 0", bus.byte_ready_out); end
    cycle();
    bad = first_bad_bit();
    checks++; if (bad != -1) begin failures++; $display("FAIL bp_frame bad bit %0d got %b want %b", bad, bus.frame_out[bad], ~bus.frame_out[bad]); end
    while (!bus.done_out && n < 3000) begin
      if (bus.byte_ready_out) ready_seen++;
      cycle();
      n++;
    end
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL bp_done_timeout got %b want 1", bus.done_out); end
    checks++; if (ready_seen != 0) begin failures++; $display("FAIL bp_ready_while_busy got %0d cycles want 0", ready_seen); end
    checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL bp_done_ready got %b want 0", bus.byte_ready_out); end
    cycle();
    checks++; if (bus.frame_cnt_out !== 16'd2) begin failures++; $display("FAIL bp_cnt got %0d want 2", bus.frame_cnt_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL bp_idle_busy got %b want 0", bus.busy_out); end
    cycle();
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL bp_aa_accept busy got %b want 1", bus.busy_out); end
    bytes_sent[0] = 8'hAA;
    send_frame(3, 1);
    bus.byte_valid_in = 1'b0;
    cycle();
    checks++; if (bus.frame_out[7:0] !== 8'hAA) begin failures++; $display("FAIL bp_aa_byte0 got %h want aa", bus.frame_out[7:0]); end
    bad = first_bad_bit();
    checks++; if (bad != -1) begin failures++; $display("FAIL bp_aa_frame bad bit %0d got %b want %b", bad, bus.frame_out[bad], ~bus.frame_out[bad]); end
    wait_done(cyc);
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL bp_aa_done_timeout got %b want 1", bus.done_out); end
    cycle();
    checks++; if (bus.frame_cnt_out !== 16'd3) begin failures++; $display("FAIL bp_aa_cnt got %0d want 3", bus.frame_cnt_out); end
  endtask

  task automatic test_stale_final();
    int dones = 0;
    model_on = 1'b0;
    forced_state = 2'd3;
    send_frame(4, 0);
    bus.byte_valid_in = 1'b0;
    cycle();
    checks++; if (bus.start_out !== 1'b1) begin failures++; $display("FAIL stale_start got %b want 1", bus.start_out); end
    repeat (10) begin cycle(); if (bus.done_out) dones++; end
    forced_state = 2'd1;
    repeat (3) begin cycle(); if (bus.done_out) dones++; end
    forced_state = 2'd2;
    cycle();
    if (bus.done_out) dones++;
    forced_state = 2'd3;
    checks++; if (dones != 0) begin failures++; $display("FAIL stale_early_done got %0d pulses want 0", dones); end
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL stale_busy got %b want 1", bus.busy_out); end
    cycle();
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL stale_done got %b want 1", bus.done_out); end
    cycle();
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL stale_done_width got %b want 0", bus.done_out); end
    checks++; if (bus.frame_cnt_out !== 16'd4) begin failures++; $display("FAIL stale_cnt got %0d want 4", bus.frame_cnt_out); end
  endtask

  task automatic test_gap_timeout();
    int bad;
    int cyc;
    model_on = 1'b1;
    for (int k = 0; k < 50; k++) send_byte(pat(1, k));
    bus.byte_valid_in = 1'b0;
    repeat (GAP_CYCLES - 1) cycle();
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL gap_edge_busy got %b want 1", bus.busy_out); end
    send_byte(pat(1, 50));
    bus.byte_valid_in = 1'b0;
    checks++; if (bus.busy_out !== 1'b1 || bus.err_code_out !== 2'd0) begin failures++; $display("FAIL gap_cancel busy=%b err=%0d want busy=1 err=0", bus.busy_out, bus.err_code_out); end
    repeat (GAP_CYCLES - 1) cycle();
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL gap_pre_busy got %b want 1", bus.busy_out); end
    cycle();
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL gap_to_idle busy got %b want 0", bus.busy_out); end
    checks++; if (bus.err_code_out !== 2'd1) begin failures++; $display("FAIL gap_err got %0d want 1", bus.err_code_out); end
    checks++; if (bus.byte_ready_out !== 1'b1) begin failures++; $display("FAIL gap_ready got %b want 1", bus.byte_ready_out); end
    bytes_sent[0] = pat(5, 0);
    send_byte(bytes_sent[0]);
    checks++; if (bus.err_code_out !== 2'd0) begin failures++; $display("FAIL gap_err_clear got %0d want 0", bus.err_code_out); end
    send_frame(5, 1);
    bus.byte_valid_in = 1'b0;
    cycle();
    bad = first_bad_bit();
    checks++; if (bad != -1) begin failures++; $display("FAIL gap_new_frame bad bit %0d got %b want %b", bad, bus.frame_out[bad], ~bus.frame_out[bad]); end
    wait_done(cyc);
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL gap_done_timeout got %b want 1", bus.done_out); end
    cycle();
    checks++; if (bus.frame_cnt_out !== 16'd5) begin failures++; $display("FAIL gap_cnt got %0d want 5", bus.frame_cnt_out); end
  endtask

  task automatic test_tx_timeout();
    int dones = 0;
    model_on = 1'b0;
    forced_state = 2'd1;
    send_frame(2, 0);
    bus.byte_valid_in = 1'b0;
    repeat (TX_TIMEOUT + 2) begin cycle(); if (bus.done_out) dones++; end
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL txto_pre_busy got %b want 1", bus.busy_out); end
    checks++; if (bus.err_code_out !== 2'd0) begin failures++; $display("FAIL txto_pre_err got %0d want 0", bus.err_code_out); end
    cycle();
    if (bus.done_out) dones++;
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL txto_busy got %b want 0", bus.busy_out); end
    checks++; if (bus.err_code_out !== 2'd2) begin failures++; $display("FAIL txto_err got %0d want 2", bus.err_code_out); end
    checks++; if (bus.frame_cnt_out !== 16'd5) begin failures++; $display("FAIL txto_cnt got %0d want 5", bus.frame_cnt_out); end
    checks++; if (dones != 0) begin failures++; $display("FAIL txto_done got %0d pulses want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid_frame();
    test_back_to_back();
    test_stale_final();
    test_gap_timeout();
    test_tx_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_frame_loader.md
# sc_frame_loader

Upstream feeder for the MAROC slow-control serial transmitter. Accepts the 829-bit configuration frame as a byte stream from the host link (valid/ready), assembles it in a shadow register, and publishes it on a stable parallel bus. It then issues a one-cycle start to the transmitter and supervises the transfer through the transmitter's 2-bit state output, reporting completion or timeout.

## Interface
- FRAME_BITS, 829, configuration frame length; bit 0 is shifted to MAROC first
- BYTE_COUNT, 104, bytes per frame, equal to ceil(FRAME_BITS/8)
- GAP_CYCLES, 4096, maximum clk_in cycles allowed between accepted bytes inside a frame
- TX_TIMEOUT, 2047, maximum cycles from start to transmitter FINAL

- clk_in  in  1  5 MHz system clock, same clock as the transmitter
- reset_in  in  1  reset, asynchronous, active-high
- byte_in  in  8  frame byte from the host link
- byte_valid_in  in  1  byte_in is valid
- byte_ready_out  out  1  loader can accept a byte
- frame_out  out  FRAME_BITS  assembled frame; drives the transmitter's field inputs
- start_out  out  1  one-cycle start request to the transmitter
- tx_state_in  in  2  transmitter state: 0 IDLE, 1 PREPARE, 2 SENDING, 3 FINAL
- busy_out  out  1  high in every state except IDLE
- done_out  out  1  one-cycle pulse when a transfer completes
- err_code_out  out  2  last error: 0 none, 1 gap timeout, 2 tx timeout
- frame_cnt_out  out  16  completed-transfer counter

## Operation
- A byte is accepted on a rising edge with byte_valid_in && byte_ready_out.
- Byte k is written to shadow[8k+7:8k].
  - Byte 0 maps to frame bits [7:0].
  - Bits 5..7 of byte 103 map above FRAME_BITS-1 and are discarded.
- byte_cnt is 7 bits and counts 0..BYTE_COUNT-1.
- gap_ctr is 13 bits and is cleared on every accepted byte.
- tx_ctr is 11 bits.
- FSM states:
  - IDLE: ready=1. Accepting a byte moves to RECV, sets byte_cnt=1, and clears err_code_out to 0.
  - RECV: ready=1.
    - Each accepted byte increments byte_cnt.
    - Accepting byte BYTE_COUNT-1 moves to LOAD.
    - If gap_ctr reaches GAP_CYCLES-1 with no byte accepted: err_code_out=1, byte_cnt=0, go to IDLE. The shadow contents are don't-care.
  - LOAD: ready=0. frame_out <= shadow. Go to START.
  - START: ready=0, start_out=1 (Moore output). Clear tx_ctr and seen_send. Go to WAIT.
  - WAIT: ready=0.
    - tx_ctr increments each cycle.
    - tx_state_in==2 sets seen_send.
    - seen_send && tx_state_in==3 moves to DONE. A stale FINAL left over from the previous transfer is ignored because seen_send is clear.
    - If tx_ctr reaches TX_TIMEOUT: err_code_out=2, go to IDLE, frame_cnt_out unchanged.
  - DONE: done_out=1, frame_cnt_out increments (wraps 0xFFFF→0), go to IDLE.
- frame_out changes only in LOAD. It holds from LOAD through the end of the next transfer.
- Bytes presented while ready=0 are not consumed; the host must hold them.
- A gap timeout and a first byte in the same cycle cannot occur, because the timeout only fires in RECV. In RECV, an accepted byte on the timeout cycle takes priority and the timeout is cancelled.

## Timing
- Reset values:
  - State IDLE.
  - byte_ready_out=1.
  - frame_out=0, shadow=0.
  - start_out=0, busy_out=0, done_out=0.
  - err_code_out=0, frame_cnt_out=0.
  - All internal counters 0.
- Reset asserted mid-operation, in any state: all of the above immediately; a partial frame is lost.
- Last byte accepted at edge E0:
  - E1: frame_out valid.
  - E1→E2: start_out high for exactly one cycle.
  - The transmitter samples start_in at E2, while frame_out has already been stable for one cycle.
- Completion: tx_state_in==3 with seen_send sampled at edge Ef. DONE occupies the cycle after Ef; done_out is high for exactly one cycle.
- Nominal transfer: start to DONE ≈ 832 cycles, below TX_TIMEOUT.
- Minimum frame ingest is 104 cycles, with one byte per cycle sustained in IDLE/RECV.

## Test plan
- Reset: assert reset_in mid-RECV after 40 bytes → all outputs at reset values. Then 104 fresh bytes form a complete frame.
- Nominal: bytes 0x00..0x67 back-to-back, with a behavioral transmitter model (1 for 1 cycle, 2 for 829 cycles, then 3).
  - frame_out[7:0]=0x00, [15:8]=0x01, [828:824]=0x07.
  - start_out pulses once, two edges after the last byte.
  - done_out pulses once; frame_cnt_out=1; err_code_out=0.
- Backpressure: hold byte_valid_in=1 with 0xAA during LOAD/START/WAIT → no byte consumed, ready=0. The next frame's byte 0 is 0xAA, accepted only after DONE.
- Stale FINAL: tx_state_in=3 when start_out is issued, then 1, 2, 3 → no done until after state 2 is observed.
- Gap timeout: 50 bytes then idle GAP_CYCLES cycles → err_code_out=1, IDLE. Then 104 bytes produce a correct new frame with err_code_out cleared to 0.
- TX timeout: tx_state_in stuck at 1 → after TX_TIMEOUT cycles err_code_out=2, busy_out=0, frame_cnt_out unchanged, no done_out.
